// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// State codes are plain 2-bit constants so older tools can read them.
package serial_sub_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // Bit count needed to index 0..s-1, never less than one bit.
    function automatic int CW(input int s);
        int c;
        c = $clog2(s);
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/serial_sub_full_sub.sv
// Single-bit full subtractor: diff = a - b - bin, with borrow out.
// Purely combinational; the top reuses one instance every cycle.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial two's-complement subtractor, LSB first, one bit per clock.
// Results and flags are registered and held until the next completion.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int size = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [size-1:0] i0,
    input  logic [size-1:0] i1,
    output logic            busy,
    output logic            done,
    output logic [size-1:0] d,
    output logic            bo,
    output logic            ov,
    output logic            z
);

    localparam int CWD = CW(size);

    state_t          state_q, state_d;
    logic [size-1:0] a_q, a_d;
    logic [size-1:0] b_q, b_d;
    logic [size-1:0] r_q, r_d;
    logic [CWD-1:0]  cnt_q, cnt_d;
    logic            bw_q, bw_d;
    logic            s0_q, s0_d;
    logic            s1_q, s1_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [size-1:0] d_q, d_d;
    logic            bo_q, bo_d;
    logic            ov_q, ov_d;
    logic            z_q, z_d;

    logic            diff;
    logic            bout;
    logic            last;
    logic [size-1:0] dbit;
    logic [size-1:0] res_nxt;

    full_sub u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (bw_q),
        .diff (diff),
        .bout (bout)
    );

    assign last = (cnt_q == CWD'(size - 1));

    // Result register with this cycle's difference bit entering at the MSB.
    always_comb begin
        dbit = '0;
        dbit[size-1] = diff;
        res_nxt = (r_q >> 1) | dbit;
    end

    // Next-state: start capture, serial step, completion and abort.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        bw_d    = bw_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        d_d     = d_q;
        bo_d    = bo_q;
        ov_d    = ov_q;
        z_d     = z_q;
        unique case (state_q)
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    a_d   = a_q >> 1;
                    b_d   = b_q >> 1;
                    r_d   = res_nxt;
                    bw_d  = bout;
                    cnt_d = cnt_q + CWD'(1);
                    if (last) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        d_d     = res_nxt;
                        bo_d    = bout;
                        ov_d    = (s0_q != s1_q) && (diff != s0_q);
                        z_d     = (res_nxt == '0);
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    a_d     = i0;
                    b_d     = i1;
                    r_d     = '0;
                    bw_d    = 1'b0;
                    cnt_d   = '0;
                    s0_d    = i0[size-1];
                    s1_d    = i1[size-1];
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            bw_q    <= 1'b0;
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            d_q     <= '0;
            bo_q    <= 1'b0;
            ov_q    <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            bw_q    <= bw_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            d_q     <= d_d;
            bo_q    <= bo_d;
            ov_q    <= ov_d;
            z_q     <= z_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bo   = bo_q;
    assign ov   = ov_q;
    assign z    = z_q;

endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub: three widths (8, 1, 32) against an arithmetic model.
// Directed vectors plus random sweeps; outputs compared every cycle.
module tb_serial_sub;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st [3];
    logic        ab [3];
    logic [31:0] ai [3];
    logic [31:0] bi [3];

    logic        bsy [3];
    logic        dn  [3];
    logic        bo_w[3];
    logic        ov_w[3];
    logic        z_w [3];
    logic [31:0] dv  [3];
    logic [7:0]  d8;
    logic [0:0]  d1;
    logic [31:0] d32;

    int n_cmp = 0;
    int n_bad = 0;
    int ndone[3];

    int          rem  [3];
    logic        mbusy[3];
    logic        mdone[3];
    logic [34:0] mres [3];
    logic [34:0] pend [3];

    always #5 clk = ~clk;

    serial_sub #(.size(8)) u8 (
        .clk(clk), .rst(rst), .start(st[0]), .abort(ab[0]),
        .i0(ai[0][7:0]), .i1(bi[0][7:0]),
        .busy(bsy[0]), .done(dn[0]), .d(d8),
        .bo(bo_w[0]), .ov(ov_w[0]), .z(z_w[0])
    );

    serial_sub #(.size(1)) u1 (
        .clk(clk), .rst(rst), .start(st[1]), .abort(ab[1]),
        .i0(ai[1][0:0]), .i1(bi[1][0:0]),
        .busy(bsy[1]), .done(dn[1]), .d(d1),
        .bo(bo_w[1]), .ov(ov_w[1]), .z(z_w[1])
    );

    serial_sub #(.size(32)) u32 (
        .clk(clk), .rst(rst), .start(st[2]), .abort(ab[2]),
        .i0(ai[2]), .i1(bi[2]),
        .busy(bsy[2]), .done(dn[2]), .d(d32),
        .bo(bo_w[2]), .ov(ov_w[2]), .z(z_w[2])
    );

    assign dv[0] = {24'h0, d8};
    assign dv[1] = {31'h0, d1};
    assign dv[2] = d32;

    function automatic int sz(input int k);
        return (k == 0) ? 8 : ((k == 1) ? 1 : 32);
    endfunction

    function automatic logic [31:0] mk(input int s);
        return (s >= 32) ? 32'hFFFF_FFFF : ((32'd1 << s) - 32'd1);
    endfunction

    // Reference arithmetic: returns {bo, ov, z, d}.
    function automatic logic [34:0] calc(input int k,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
        logic [31:0] m, am, bm, r;
        logic s0, s1, sd, o;
        int s;
        s  = sz(k);
        m  = mk(s);
        am = a & m;
        bm = b & m;
        r  = (am - bm) & m;
        s0 = am[s-1];
        s1 = bm[s-1];
        sd = r[s-1];
        o  = (s0 != s1) && (sd != s0);
        return {am < bm, o, r == 32'h0, r};
    endfunction

    function automatic logic [36:0] got(input int k);
        return {bsy[k], dn[k], bo_w[k], ov_w[k], z_w[k], dv[k]};
    endfunction

    // Model: an accepted start yields a result exactly size edges later.
    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                rem[k]   <= 0;
                mbusy[k] <= 1'b0;
                mdone[k] <= 1'b0;
                mres[k]  <= '0;
                pend[k]  <= '0;
            end else if (rem[k] > 0) begin
                if (ab[k]) begin
                    rem[k]   <= 0;
                    mbusy[k] <= 1'b0;
                end else if (rem[k] == 1) begin
                    rem[k]   <= 0;
                    mbusy[k] <= 1'b0;
                    mdone[k] <= 1'b1;
                    mres[k]  <= pend[k];
                end else begin
                    rem[k] <= rem[k] - 1;
                end
            end else begin
                mdone[k] <= 1'b0;
                if (st[k]) begin
                    rem[k]   <= sz(k);
                    mbusy[k] <= 1'b1;
                    pend[k]  <= calc(k, ai[k], bi[k]);
                end
            end
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (dn[k]) ndone[k]++;
                if (got(k) !== {mbusy[k], mdone[k], mres[k]}) begin
                    n_bad++;
                    $display("FAIL cyc[%0d]: got %h want %h", k, got(k),
                             {mbusy[k], mdone[k], mres[k]});
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] g,
                       input logic [63:0] e);
        n_cmp++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, g, e);
        end
    endtask

    task automatic op(input int k, input logic [31:0] a,
                      input logic [31:0] b, input logic abt);
        int lat;
        st[k] = 1'b1;
        ab[k] = abt;
        ai[k] = a;
        bi[k] = b;
        @(negedge clk);
        st[k] = 1'b0;
        ab[k] = 1'b0;
        ai[k] = $urandom;
        bi[k] = $urandom;
        chk("accept", 64'({bsy[k], dn[k]}), 64'(2'b10));
        lat = 0;
        while (!dn[k] && lat < sz(k) + 4) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(sz(k)));
    endtask

    // Directed scenarios followed by random sweeps.
    initial begin
        int n0;
        logic [31:0] pa, pb;
        logic [31:0] corner [5];
        corner[0] = 32'h0;
        corner[1] = 32'h1;
        corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h7FFF_FFFF;
        corner[4] = 32'h8000_0000;
        for (int k = 0; k < 3; k++) begin
            st[k] = 1'b0;
            ab[k] = 1'b0;
            ai[k] = '0;
            bi[k] = '0;
            ndone[k] = 0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) chk("reset", 64'(got(k)), 64'h0);
        rst = 1'b0;

        st[0] = 1'b1; ai[0] = 32'h5A; bi[0] = 32'h21;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst", 64'(got(0)), 64'h0);
        rst = 1'b0;
        n0 = ndone[0];
        repeat (12) @(negedge clk);
        chk("nodone_rst", 64'(ndone[0]), 64'(n0));

        op(0, 32'h5A, 32'h21, 1'b0);
        chk("5A-21", 64'(got(0)), 64'({2'b01, 3'b000, 32'h39}));
        op(0, 32'h00, 32'h01, 1'b0);
        chk("00-01", 64'(got(0)), 64'({2'b01, 3'b100, 32'hFF}));
        op(0, 32'h80, 32'h01, 1'b1);
        chk("80-01", 64'(got(0)), 64'({2'b01, 3'b010, 32'h7F}));
        op(0, 32'hC3, 32'hC3, 1'b0);
        chk("C3-C3", 64'(got(0)), 64'({2'b01, 3'b001, 32'h00}));
        n0 = ndone[0];
        op(0, 32'h10, 32'h01, 1'b0);
        chk("b2b", 64'(got(0)), 64'({2'b01, 3'b000, 32'h0F}));
        chk("b2b_once", 64'(ndone[0]), 64'(n0 + 1));

        @(negedge clk);
        n0 = ndone[0];
        st[0] = 1'b1; ai[0] = 32'h22; bi[0] = 32'h11;
        @(negedge clk);
        st[0] = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            st[0] = (i == 2 || i == 4);
            ai[0] = 32'hAA;
            bi[0] = 32'h55;
            if (i == 5) chk("ign_start", 64'(bsy[0]), 64'h1);
            ab[0] = (i == 7);
        end
        @(negedge clk);
        ab[0] = 1'b0;
        chk("abort", 64'(got(0)), 64'({2'b00, 3'b000, 32'h0F}));
        repeat (10) @(negedge clk);
        chk("abort_nodone", 64'(ndone[0]), 64'(n0));

        op(1, 32'h0, 32'h1, 1'b0);
        chk("s1 0-1", 64'(got(1)), 64'({2'b01, 3'b110, 32'h1}));
        op(1, 32'h1, 32'h0, 1'b0);
        chk("s1 1-0", 64'(got(1)), 64'({2'b01, 3'b000, 32'h1}));
        for (int i = 0; i < 500; i++)
            op(1, $urandom, $urandom, 1'b0);

        op(2, 32'h8000_0000, 32'h1, 1'b0);
        chk("s32 ov", 64'(got(2)), 64'({2'b01, 3'b010, 32'h7FFF_FFFF}));
        op(2, 32'h1234_5678, 32'h1234_5679, 1'b0);
        chk("s32 bo", 64'(got(2)), 64'({2'b01, 3'b100, 32'hFFFF_FFFF}));
        for (int i = 0; i < 500; i++) begin
            pa = (i % 4 == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            pb = (i % 3 == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            op(2, pa, pb, 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
